// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor: counter states,
// BTB entry layout and the saturating 2-bit counter update.
package bp_pkg;

  localparam int PHT_IDX_W = 8;
  // Tag field is sized for the smallest useful BTB; unused upper bits stay zero.
  localparam int BTB_TAG_W = 30;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic                 is_jump;
  } btb_entry_t;

  function automatic logic [1:0] sat2_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (cnt == ST) nxt = ST;
      else           nxt = cnt + 2'd1;
    end else begin
      if (cnt == SNT) nxt = SNT;
      else            nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and EX training signals between the pipeline (master) and
// the branch predictor (slave).
interface branch_predictor_if;
  logic [31:0] F_PC;
  logic        F_pred_taken;
  logic [7:0]  F_pht_idx;
  logic        F_btb_hit;
  logic [31:0] F_btb_target;
  logic        E_br_valid;
  logic        E_is_jump;
  logic [31:0] E_PC;
  logic        E_taken;
  logic [31:0] E_target;
  logic [7:0]  E_pht_idx;
  logic        E_mispredict;

  modport master (
    output F_PC, E_br_valid, E_is_jump, E_PC, E_taken, E_target, E_pht_idx, E_mispredict,
    input  F_pred_taken, F_pht_idx, F_btb_hit, F_btb_target
  );

  modport slave (
    input  F_PC, E_br_valid, E_is_jump, E_PC, E_taken, E_target, E_pht_idx, E_mispredict,
    output F_pred_taken, F_pht_idx, F_btb_hit, F_btb_target
  );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational read, synchronous write
// and synchronous clear of all entries.
module bp_btb
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic [31:0] rd_target,
  output logic        rd_is_jump,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target,
  input  logic        wr_is_jump
);

  localparam int IDX_W = $clog2(ENTRIES);

  function automatic logic [IDX_W-1:0] btb_idx(input logic [29:0] word_addr);
    return word_addr[IDX_W-1:0];
  endfunction

  function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [29:0] word_addr);
    return BTB_TAG_W'(word_addr >> IDX_W);
  endfunction

  btb_entry_t entries_q [ENTRIES];
  btb_entry_t entries_d [ENTRIES];
  btb_entry_t rd_entry_s;
  logic       unused_pc_bits_s;

  assign unused_pc_bits_s = ^{rd_pc[1:0], wr_pc[1:0]};

  // Write port: a taken resolution overwrites whatever alias held the slot.
  always_comb begin
    entries_d = entries_q;
    if (wr_en) begin
      entries_d[btb_idx(wr_pc[31:2])] = '{valid:   1'b1,
                                          tag:     btb_tag(wr_pc[31:2]),
                                          target:  wr_target,
                                          is_jump: wr_is_jump};
    end else begin
      entries_d = entries_q;
    end
  end

  always_comb begin
    rd_entry_s = entries_q[btb_idx(rd_pc[31:2])];
    rd_hit     = rd_entry_s.valid && (rd_entry_s.tag == btb_tag(rd_pc[31:2]));
    if (rd_hit) begin
      rd_target  = rd_entry_s.target;
      rd_is_jump = rd_entry_s.is_jump;
    end else begin
      rd_target  = 32'd0;
      rd_is_jump = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare branch predictor (PHT of 2-bit counters + non-speculative GHR) with a
// direct-mapped BTB. Optional perf counters are built when BP_PERF_CNT_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         GHR_BITS    = 8,
  parameter int         BTB_ENTRIES = 16,
  parameter logic [1:0] PHT_INIT    = WNT
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp,
  output logic [31:0]        perf_branches,
  output logic [31:0]        perf_mispredicts
);

  localparam int PHT_SIZE = 2 ** PHT_IDX_W;

  logic [1:0]          pht_q [PHT_SIZE];
  logic [1:0]          pht_d [PHT_SIZE];
  logic [GHR_BITS-1:0] ghr_q;
  logic [GHR_BITS-1:0] ghr_d;
  logic [7:0]          pht_idx_s;
  logic                btb_hit_s;
  logic                btb_is_jump_s;
  logic [31:0]         btb_target_s;

  bp_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (clk),
    .rst        (rst),
    .rd_pc      (bp.F_PC),
    .rd_hit     (btb_hit_s),
    .rd_target  (btb_target_s),
    .rd_is_jump (btb_is_jump_s),
    .wr_en      (bp.E_br_valid & bp.E_taken),
    .wr_pc      (bp.E_PC),
    .wr_target  (bp.E_target),
    .wr_is_jump (bp.E_is_jump)
  );

  // Lookup reads only registered state, so a same-cycle update is not visible.
  always_comb begin
    pht_idx_s       = bp.F_PC[9:2] ^ ghr_q;
    bp.F_pht_idx    = pht_idx_s;
    bp.F_btb_hit    = btb_hit_s;
    bp.F_btb_target = btb_target_s;
    bp.F_pred_taken = btb_hit_s & (btb_is_jump_s | (pht_q[pht_idx_s] >= WT));
  end

  always_comb begin
    pht_d = pht_q;
    ghr_d = ghr_q;
    if (bp.E_br_valid && !bp.E_is_jump) begin
      pht_d[bp.E_pht_idx] = sat2_update(pht_q[bp.E_pht_idx], bp.E_taken);
      ghr_d               = {ghr_q[GHR_BITS-2:0], bp.E_taken};
    end else begin
      pht_d = pht_q;
      ghr_d = ghr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_SIZE; i++) pht_q[i] <= PHT_INIT;
      ghr_q <= '0;
    end else begin
      pht_q <= pht_d;
      ghr_q <= ghr_d;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mp_q, perf_mp_d;

  // Saturating event counters.
  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (bp.E_br_valid && (perf_br_q != 32'hFFFF_FFFF)) perf_br_d = perf_br_q + 32'd1;
    else                                               perf_br_d = perf_br_q;
    if (bp.E_br_valid && bp.E_mispredict && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_d = perf_mp_q + 32'd1;
    else                                                                  perf_mp_d = perf_mp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q <= 32'd0;
      perf_mp_q <= 32'd0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`else
  logic unused_perf_s;
  assign unused_perf_s    = bp.E_mispredict;
  assign perf_branches    = 32'd0;
  assign perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; expectations are hand-computed
// from the gshare/BTB rules and tracked GHR values.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
  int          passed;
  int          total;

  branch_predictor_if bp();

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .bp               (bp),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bp.E_br_valid = 1'b0;
    bp.E_mispredict = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic is_jump, input logic [7:0] idx, input logic mp);
    @(negedge clk);
    bp.E_PC = pc; bp.E_taken = taken; bp.E_target = tgt;
    bp.E_is_jump = is_jump; bp.E_pht_idx = idx; bp.E_mispredict = mp;
    bp.E_br_valid = 1'b1;
    @(negedge clk);
    bp.E_br_valid = 1'b0;
    bp.E_mispredict = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    bp.F_PC = pc;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    lookup(32'h100);
    total++; if (bp.F_btb_hit !== 1'b0) $display("FAIL reset_hit got=%0h exp=0", bp.F_btb_hit); else passed++;
    total++; if (bp.F_pred_taken !== 1'b0) $display("FAIL reset_pred got=%0h exp=0", bp.F_pred_taken); else passed++;
    total++; if (bp.F_btb_target !== 32'h0) $display("FAIL reset_target got=%0h exp=0", bp.F_btb_target); else passed++;
    total++; if (bp.F_pht_idx !== 8'h40) $display("FAIL reset_idx got=%0h exp=40", bp.F_pht_idx); else passed++;
    total++; if (perf_branches !== 32'd0) $display("FAIL reset_perf_br got=%0d exp=0", perf_branches); else passed++;
  endtask

  task automatic test_taken_cond();
    do_reset();
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h40, 1'b0);
    lookup(32'h100);
    total++; if (bp.F_btb_hit !== 1'b1) $display("FAIL cond_hit got=%0h exp=1", bp.F_btb_hit); else passed++;
    total++; if (bp.F_btb_target !== 32'h200) $display("FAIL cond_target got=%0h exp=200", bp.F_btb_target); else passed++;
    total++; if (bp.F_pht_idx !== 8'h41) $display("FAIL cond_idx got=%0h exp=41", bp.F_pht_idx); else passed++;
    total++; if (bp.F_pred_taken !== 1'b0) $display("FAIL cond_pred got=%0h exp=0", bp.F_pred_taken); else passed++;
  endtask

  // BTB entries at 0xFC/0x2F8/0x2F0 are placed so each maps to PHT[0x40] at the
  // GHR value reached when it is probed (0x7F, 0xFE, 0xFC).
  task automatic test_saturation();
    do_reset();
    resolve(32'h0FC, 1'b1, 32'h400, 1'b0, 8'h99, 1'b0);
    resolve(32'h2F8, 1'b1, 32'h404, 1'b0, 8'h99, 1'b0);
    resolve(32'h2F0, 1'b1, 32'h408, 1'b0, 8'h99, 1'b0);
    for (int i = 0; i < 4; i++) resolve(32'h0FC, 1'b1, 32'h400, 1'b0, 8'h40, 1'b0);
    lookup(32'h0FC);
    total++; if (bp.F_pht_idx !== 8'h40) $display("FAIL sat_idx got=%0h exp=40", bp.F_pht_idx); else passed++;
    total++; if (bp.F_pred_taken !== 1'b1) $display("FAIL sat_pred_st got=%0h exp=1", bp.F_pred_taken); else passed++;
    resolve(32'h0FC, 1'b0, 32'h0, 1'b0, 8'h40, 1'b0);
    lookup(32'h2F8);
    total++; if (bp.F_pred_taken !== 1'b1) $display("FAIL sat_pred_wt got=%0h exp=1", bp.F_pred_taken); else passed++;
    resolve(32'h0FC, 1'b0, 32'h0, 1'b0, 8'h40, 1'b0);
    lookup(32'h2F0);
    total++; if (bp.F_btb_hit !== 1'b1) $display("FAIL sat_hit got=%0h exp=1", bp.F_btb_hit); else passed++;
    total++; if (bp.F_pred_taken !== 1'b0) $display("FAIL sat_pred_wnt got=%0h exp=0", bp.F_pred_taken); else passed++;
  endtask

  task automatic test_jump();
    do_reset();
    resolve(32'h300, 1'b1, 32'h80, 1'b1, 8'hC0, 1'b0);
    lookup(32'h300);
    total++; if (bp.F_pht_idx !== 8'hC0) $display("FAIL jump_idx got=%0h exp=c0", bp.F_pht_idx); else passed++;
    total++; if (bp.F_btb_hit !== 1'b1) $display("FAIL jump_hit got=%0h exp=1", bp.F_btb_hit); else passed++;
    total++; if (bp.F_btb_target !== 32'h80) $display("FAIL jump_target got=%0h exp=80", bp.F_btb_target); else passed++;
    total++; if (bp.F_pred_taken !== 1'b1) $display("FAIL jump_pred got=%0h exp=1", bp.F_pred_taken); else passed++;
  endtask

  task automatic test_alias();
    do_reset();
    resolve(32'h104, 1'b1, 32'h600, 1'b0, 8'h41, 1'b0);
    lookup(32'h104);
    total++; if (bp.F_btb_target !== 32'h600) $display("FAIL alias_first got=%0h exp=600", bp.F_btb_target); else passed++;
    resolve(32'h144, 1'b1, 32'h500, 1'b0, 8'h50, 1'b0);
    lookup(32'h104);
    total++; if (bp.F_btb_hit !== 1'b0) $display("FAIL alias_evicted_hit got=%0h exp=0", bp.F_btb_hit); else passed++;
    total++; if (bp.F_btb_target !== 32'h0) $display("FAIL alias_evicted_tgt got=%0h exp=0", bp.F_btb_target); else passed++;
    lookup(32'h144);
    total++; if (bp.F_btb_hit !== 1'b1) $display("FAIL alias_new_hit got=%0h exp=1", bp.F_btb_hit); else passed++;
    total++; if (bp.F_btb_target !== 32'h500) $display("FAIL alias_new_tgt got=%0h exp=500", bp.F_btb_target); else passed++;
    resolve(32'h144, 1'b0, 32'h999, 1'b0, 8'h53, 1'b0);
    lookup(32'h144);
    total++; if (bp.F_btb_target !== 32'h500) $display("FAIL alias_nt_keep got=%0h exp=500", bp.F_btb_target); else passed++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h40, 1'b0);
    bp.F_PC = 32'h100;
    bp.E_PC = 32'h100; bp.E_taken = 1'b1; bp.E_target = 32'h240;
    bp.E_is_jump = 1'b0; bp.E_pht_idx = 8'h41; bp.E_br_valid = 1'b1;
    #1;
    total++; if (bp.F_btb_target !== 32'h200) $display("FAIL same_old_tgt got=%0h exp=200", bp.F_btb_target); else passed++;
    total++; if (bp.F_pred_taken !== 1'b0) $display("FAIL same_old_pred got=%0h exp=0", bp.F_pred_taken); else passed++;
    @(negedge clk);
    bp.E_br_valid = 1'b0;
    #1;
    total++; if (bp.F_btb_target !== 32'h240) $display("FAIL same_new_tgt got=%0h exp=240", bp.F_btb_target); else passed++;
    total++; if (bp.F_pht_idx !== 8'h43) $display("FAIL same_new_idx got=%0h exp=43", bp.F_pht_idx); else passed++;
  endtask

  task automatic test_reset_coincident();
    @(negedge clk);
    rst = 1'b1;
    bp.E_PC = 32'h380; bp.E_taken = 1'b1; bp.E_target = 32'h900;
    bp.E_is_jump = 1'b0; bp.E_pht_idx = 8'h00; bp.E_br_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bp.E_br_valid = 1'b0;
    lookup(32'h380);
    total++; if (bp.F_btb_hit !== 1'b0) $display("FAIL rstcoin_hit got=%0h exp=0", bp.F_btb_hit); else passed++;
    total++; if (bp.F_pht_idx !== 8'hE0) $display("FAIL rstcoin_idx got=%0h exp=e0", bp.F_pht_idx); else passed++;
    lookup(32'h100);
    total++; if (bp.F_btb_hit !== 1'b0) $display("FAIL rstcoin_cleared got=%0h exp=0", bp.F_btb_hit); else passed++;
  endtask

  task automatic test_perf();
    logic [31:0] exp_br;
    logic [31:0] exp_mp;
    do_reset();
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h40, 1'b1);
    resolve(32'h104, 1'b0, 32'h0,   1'b0, 8'h41, 1'b0);
    resolve(32'h300, 1'b1, 32'h80,  1'b1, 8'hC0, 1'b0);
    resolve(32'h100, 1'b0, 32'h0,   1'b0, 8'h42, 1'b1);
    resolve(32'h108, 1'b1, 32'h20,  1'b0, 8'h43, 1'b0);
    @(negedge clk);
    bp.E_mispredict = 1'b1;
    @(negedge clk);
    bp.E_mispredict = 1'b0;
`ifdef BP_PERF_CNT_EN
    exp_br = 32'd5;
    exp_mp = 32'd2;
`else
    exp_br = 32'd0;
    exp_mp = 32'd0;
`endif
    total++; if (perf_branches !== exp_br) $display("FAIL perf_branches got=%0d exp=%0d", perf_branches, exp_br); else passed++;
    total++; if (perf_mispredicts !== exp_mp) $display("FAIL perf_mispredicts got=%0d exp=%0d", perf_mispredicts, exp_mp); else passed++;
    do_reset();
    total++; if (perf_mispredicts !== 32'd0) $display("FAIL perf_cleared got=%0d exp=0", perf_mispredicts); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    bp.F_PC = 32'h0; bp.E_br_valid = 1'b0; bp.E_is_jump = 1'b0; bp.E_PC = 32'h0;
    bp.E_taken = 1'b0; bp.E_target = 32'h0; bp.E_pht_idx = 8'h0; bp.E_mispredict = 1'b0;
    test_reset();
    test_taken_cond();
    test_saturation();
    test_jump();
    test_alias();
    test_same_cycle();
    test_reset_coincident();
    test_perf();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-side branch predictor: gshare PHT of 2-bit counters plus a direct-mapped BTB.
- Produces F_pred_taken, F_pht_idx, F_btb_hit and F_btb_target for the IF stage; these travel through the IF/ID register to later stages.
- EX returns the resolved outcome, together with the pht_idx carried down the pipe, to train the tables.
- Sits beside the PC mux; its redirect is taken when F_pred_taken=1.

Parameters:
GHR_BITS, 8, global history length; equals PHT index width (fixed 8 to match pipeline pht_idx field)
BTB_ENTRIES, 16, direct-mapped BTB entries; power of 2
PHT_INIT, 2'b01, counter reset value (weakly not-taken)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
F_PC  in  32  current fetch PC
F_pred_taken  out  1  predict taken, redirect fetch to F_btb_target
F_pht_idx  out  8  PHT index used for this lookup
F_btb_hit  out  1  BTB tag match with valid entry
F_btb_target  out  32  BTB target (0 on miss)
E_br_valid  in  1  one-cycle pulse: resolved control-flow instr in EX
E_is_jump  in  1  instr is unconditional (JAL/JALR)
E_PC  in  32  PC of resolved instr
E_taken  in  1  actual direction
E_target  in  32  actual target
E_pht_idx  in  8  pht_idx carried from fetch
perf_branches  out  32  see Optional Feature
perf_mispredicts  out  32  see Optional Feature
E_mispredict  in  1  EX flagged misprediction (counting only)

Behaviour:
- Reset is synchronous on rst=1. It clears the GHR to 0, sets all PHT counters to PHT_INIT, clears all BTB valid bits, and zeroes the perf counters.
- The combinational outputs follow from table contents.
  - After reset: F_btb_hit=0, F_pred_taken=0, F_btb_target=0, F_pht_idx=F_PC[9:2]^0.
- Lookup is combinational, zero latency, same cycle as F_PC:
  - pht_idx = F_PC[9:2] ^ GHR.
  - BTB index = F_PC[2+:log2(BTB_ENTRIES)]; tag = the remaining upper PC bits.
  - hit = valid & tag match.
  - F_pred_taken = hit & (entry.is_jump | PHT[pht_idx][1]).
  - F_btb_target = hit ? entry.target : 0.
- Update happens on the clock edge when E_br_valid=1 and rst=0.
  - Conditional (E_is_jump=0): PHT[E_pht_idx] increments if E_taken, saturating at 3; otherwise decrements, saturating at 0. GHR <= {GHR[6:0], E_taken}.
  - Jump: PHT and GHR are untouched.
  - BTB: if E_taken, write entry[idx(E_PC)] = {valid=1, tag(E_PC), E_target, E_is_jump}, overwriting any alias. If not taken, the BTB is untouched; a stale entry is left for the PHT to suppress.
- GHR is non-speculative: it is updated only at resolution, never at fetch.
- Same-cycle lookup and update to the same PHT or BTB entry: the lookup sees the pre-update (old) value. There is no bypass.
- rst asserted together with E_br_valid: reset wins and the update is dropped.
- E_br_valid is a single-cycle pulse per instruction. The instantiator qualifies it with EX stall/flush; the block does not dedupe.

Optional Feature:
Macro BP_PERF_CNT_EN.
- Defined: perf_branches increments on every E_br_valid. perf_mispredicts increments when E_br_valid & E_mispredict. Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by rst.
- Undefined: the counter logic is not built and both outputs are tied to 32'd0. The ports remain so the top level is unchanged.

Decomposition:
- Shared package bp_pkg holds:
  - localparam PHT_IDX_W=8
  - typedef btb_entry_t {valid, tag, target[31:0], is_jump}
  - constants for the 2-bit counter states SNT=0, WNT=1, WT=2, ST=3
  - function sat2_update(cnt, taken)
- One natural sub-module: bp_btb, the direct-mapped storage with combinational read and synchronous write/reset. PHT and GHR stay in the top.

Test Plan:
- Reset then F_PC=0x100 -> F_btb_hit=0, F_pred_taken=0, F_btb_target=0, F_pht_idx=0x40.
- Taken conditional branch at PC 0x100 to target 0x200: resolve with E_pht_idx=0x40. Next cycle F_PC=0x100 -> btb_hit=1, target=0x200, F_pht_idx=0x40^0x01=0x41. pred_taken follows PHT[0x41]=WNT, so 0.
- Same branch resolved taken 3 times at a fixed pht_idx 0x40, then a 4th time -> counter saturates at ST (3). Resolving not-taken twice then gives WNT, pred_taken=0.
- JAL at 0x300 to 0x80, resolved E_is_jump=1 -> GHR unchanged. Next lookup of 0x300 -> pred_taken=1 regardless of PHT.
- Aliasing: PC 0x104 and 0x144 share a BTB index. Train 0x104 taken, then 0x144 taken to 0x500 -> lookup 0x104 misses, lookup 0x144 hits with target 0x500.
- Same-cycle lookup and update of PC 0x100 -> old value observed. rst coincident with E_br_valid -> table stays at reset state. With BP_PERF_CNT_EN, 5 resolves with 2 mispredicts -> 5 / 2.
